hazard_control_unit: RTL and testbench

- Pipeline hazard controller for the 5-stage RV32I core; the stall/flush counterpart of the EX-stage forwarding logic.
- Handles three cases forwarding cannot resolve: load-use hazards (one bubble), taken branches/jumps resolved in EX (flush the younger stages), and data-memory wait states (freeze the pipe, with timeout).
- Drives the write/flush enables of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_control_unit_operand_use.sv | 25 ++
 rtl/hazard_control_unit.sv | 155 +++++++++++++++
 tb/tb_hazard_control_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard control unit:
// RV32I opcodes and the memory-wait FSM states.
package hazard_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic {
    ST_RUN,
    ST_MEM_WAIT
  } hz_state_e;

endpackage

// File: rtl/hazard_control_unit_operand_use.sv
// Opcode decode: which source registers an ID instruction reads.
// Used to avoid false load-use stalls on unused fields.
module rv_operand_use
  import hazard_pkg::*;
(
  input  logic [6:0] in_opcode,
  output logic       out_uses_rs1,
  output logic       out_uses_rs2
);

  always_comb begin
    out_uses_rs1 = 1'b1;
    out_uses_rs2 = 1'b0;
    unique case (1'b1)
      (in_opcode == OP_LUI)    ,
      (in_opcode == OP_AUIPC)  ,
      (in_opcode == OP_JAL)    : out_uses_rs1 = 1'b0;
      (in_opcode == OP_RTYPE)  ,
      (in_opcode == OP_STORE)  ,
      (in_opcode == OP_BRANCH) : out_uses_rs2 = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller: load-use, EX redirect, dmem wait+timeout.
// Optional perf counters enabled by defining HAZARD_PERF_EN.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_idex_memread,
  input  logic [4:0]       in_idex_rd,
  input  logic [6:0]       in_ifid_opcode,
  input  logic [4:0]       in_ifid_rs1,
  input  logic [4:0]       in_ifid_rs2,
  input  logic             in_ex_redirect,
  input  logic             in_exmem_memreq,
  input  logic             in_dmem_ready,
  output logic             out_pc_write,
  output logic             out_ifid_write,
  output logic             out_ifid_flush,
  output logic             out_idex_write,
  output logic             out_idex_flush,
  output logic             out_exmem_write,
  output logic             out_memwb_bubble,
  output logic             out_mem_timeout,
  output logic [CNT_W-1:0] out_stall_cycles,
  output logic [CNT_W-1:0] out_flush_count
);

  localparam int WCW = $clog2(MEM_TIMEOUT);
  localparam logic [WCW-1:0] WC_LAST = WCW'(MEM_TIMEOUT - 1);

  hz_state_e      state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           timeout_q, timeout_d;

  logic uses_rs1, uses_rs2;
  logic mem_pend, abort, freeze, load_use;

  rv_operand_use u_opuse (
    .in_opcode    (in_ifid_opcode),
    .out_uses_rs1 (uses_rs1),
    .out_uses_rs2 (uses_rs2)
  );

  always_comb begin
    mem_pend = in_exmem_memreq && !in_dmem_ready;
    abort    = (state_q == ST_MEM_WAIT) && (wait_cnt_q == WC_LAST);
    freeze   = mem_pend && !abort;
    load_use = in_idex_memread && (in_idex_rd != 5'd0)
            && ((uses_rs1 && (in_idex_rd == in_ifid_rs1))
             || (uses_rs2 && (in_idex_rd == in_ifid_rs2)));
  end

  always_comb begin
    out_pc_write     = 1'b1;
    out_ifid_write   = 1'b1;
    out_ifid_flush   = 1'b0;
    out_idex_write   = 1'b1;
    out_idex_flush   = 1'b0;
    out_exmem_write  = 1'b1;
    out_memwb_bubble = 1'b0;
    if (freeze) begin
      out_pc_write     = 1'b0;
      out_ifid_write   = 1'b0;
      out_idex_write   = 1'b0;
      out_exmem_write  = 1'b0;
      out_memwb_bubble = 1'b1;
    end else if (in_ex_redirect) begin
      // the would-be stalled ID instr is discarded anyway
      out_ifid_flush = 1'b1;
      out_idex_flush = 1'b1;
    end else if (load_use) begin
      out_pc_write   = 1'b0;
      out_ifid_write = 1'b0;
      out_idex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_pend) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_pend) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (abort) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
          timeout_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign out_mem_timeout = timeout_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (freeze || (!in_ex_redirect && load_use))
      stall_d = stall_q + CNT_W'(1);
    if (!freeze && in_ex_redirect)
      flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign out_stall_cycles = stall_q;
  assign out_flush_count  = flush_q;
`else
  assign out_stall_cycles = '0;
  assign out_flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed + random bench for hazard_control_unit (MEM_TIMEOUT=4),
// checked against a cycle-level behavioural model.
module tb_hazard_control_unit;
  import hazard_pkg::*;

  localparam int T  = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          memread = 1'b0;
  logic [4:0]    idex_rd = '0;
  logic [6:0]    opcode = OP_ITYPE;
  logic [4:0]    rs1 = '0;
  logic [4:0]    rs2 = '0;
  logic          redirect = 1'b0;
  logic          memreq = 1'b0;
  logic          ready = 1'b0;
  logic          pc_w, ifid_w, ifid_f, idex_w, idex_f;
  logic          exmem_w, memwb_b, mem_to;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_bad = 0;

  // model: consecutive frozen cycles of the current access
  int            m_run = 0;
  bit            m_to = 1'b0;
  logic [CW-1:0] m_stall = '0;
  logic [CW-1:0] m_flush = '0;

  hazard_control_unit #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .in_clk           (clk),
    .in_rst_n         (rst_n),
    .in_idex_memread  (memread),
    .in_idex_rd       (idex_rd),
    .in_ifid_opcode   (opcode),
    .in_ifid_rs1      (rs1),
    .in_ifid_rs2      (rs2),
    .in_ex_redirect   (redirect),
    .in_exmem_memreq  (memreq),
    .in_dmem_ready    (ready),
    .out_pc_write     (pc_w),
    .out_ifid_write   (ifid_w),
    .out_ifid_flush   (ifid_f),
    .out_idex_write   (idex_w),
    .out_idex_flush   (idex_f),
    .out_exmem_write  (exmem_w),
    .out_memwb_bubble (memwb_b),
    .out_mem_timeout  (mem_to),
    .out_stall_cycles (stall_cnt),
    .out_flush_count  (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] obs_vec();
    return {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_b, mem_to};
  endfunction

  task automatic cyc(input string tag, input logic mr, input logic [4:0] rd,
                     input logic [6:0] op, input logic [4:0] r1,
                     input logic [4:0] r2, input logic rdr,
                     input logic req, input logic rdy);
    bit u1, u2, lu, frz, abrt;
    logic [7:0] e;
    @(negedge clk);
    memread = mr; idex_rd = rd; opcode = op; rs1 = r1; rs2 = r2;
    redirect = rdr; memreq = req; ready = rdy;
    #1;
    u1   = !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
    u2   = op inside {OP_RTYPE, OP_STORE, OP_BRANCH};
    lu   = mr && rd != 0 && ((u1 && rd == r1) || (u2 && rd == r2));
    frz  = req && !rdy && (m_run < T - 1);
    abrt = req && !rdy && (m_run == T - 1);
    if (frz)      e = {7'b0000001, m_to};
    else if (rdr) e = {7'b1111110, m_to};
    else if (lu)  e = {7'b0001110, m_to};
    else          e = {7'b1101010, m_to};
    chk({tag, ".ctl"}, {24'b0, obs_vec()}, {24'b0, e});
    chk({tag, ".stall"}, stall_cnt, m_stall);
    chk({tag, ".flush"}, flush_cnt, m_flush);
    @(posedge clk);
    m_run = frz ? m_run + 1 : 0;
    if (abrt) m_to = 1'b1;
`ifdef HAZARD_PERF_EN
    if (frz || (!rdr && lu)) m_stall = m_stall + 1;
    if (!frz && rdr)         m_flush = m_flush + 1;
`endif
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 5'd0, OP_ITYPE, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // async reset applied mid-cycle with idle inputs
  task automatic reset_now(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    memread = 1'b0; redirect = 1'b0; memreq = 1'b0; ready = 1'b0;
    #1;
    m_run = 0; m_to = 1'b0; m_stall = '0; m_flush = '0;
    chk({tag, ".ctl"}, {24'b0, obs_vec()}, {24'b0, 8'b11010100});
    chk({tag, ".stall"}, stall_cnt, '0);
    chk({tag, ".flush"}, flush_cnt, '0);
    #2 rst_n = 1'b1;
  endtask

  logic [6:0] ops [9];

  initial begin
    ops = '{OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    #2;
    reset_now("reset");
    idle("idle0");
    // load-use: lw x5 ; add x6,x5,x1
    cyc("lu", 1'b1, 5'd5, OP_RTYPE, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
    cyc("lu_next", 1'b0, 5'd0, OP_RTYPE, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
    // addi x6,x0,5: rs2 field matches but is unused
    cyc("addi_nf", 1'b1, 5'd5, OP_ITYPE, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
    cyc("x0_nf", 1'b1, 5'd0, OP_RTYPE, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("lui_nf", 1'b1, 5'd7, OP_LUI, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0);
    cyc("st_rs2", 1'b1, 5'd7, OP_STORE, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0);
    cyc("redir_lu", 1'b1, 5'd5, OP_RTYPE, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0);
    cyc("redir", 1'b0, 5'd0, OP_ITYPE, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    // 3 wait cycles then ready in the 4th (counter at its last value)
    for (int i = 0; i < 3; i++)
      cyc("mwait", 1'b0, 5'd0, OP_ITYPE, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    cyc("mready", 1'b0, 5'd0, OP_ITYPE, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    cyc("zero_wait", 1'b0, 5'd0, OP_ITYPE, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle("after_wait");
    // timeout: freeze 3, abort on the 4th, sticky flag
    for (int i = 0; i < 4; i++)
      cyc("tmo", 1'b0, 5'd0, OP_ITYPE, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    idle("tmo_sticky");
    idle("tmo_sticky2");
    reset_now("tmo_reset");
    idle("post_reset");
    // reset during MEM_WAIT, then a full wait must still take T cycles
    cyc("rw1", 1'b0, 5'd0, OP_ITYPE, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc("rw2", 1'b0, 5'd0, OP_ITYPE, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    reset_now("rst_wait");
    for (int i = 0; i < 4; i++)
      cyc("rw_tmo", 1'b0, 5'd0, OP_ITYPE, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    reset_now("rst2");
    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc("rand",
          1'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)),
          ops[$urandom_range(0, 8)],
          5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)),
          1'($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 9) < 4),
          1'($urandom_range(0, 2) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
